// File: rtl/shake_hand_pkg.sv
// Shared types and helpers for the four-phase handshake receive buffer.
package shake_hand_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2
  } hs_state_t;

  // Ceiling log2, usable in parameter and localparam expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with registered occupancy count.
module sync_fifo
  import shake_hand_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  output logic [DATA_W-1:0]            head,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [LVL_W-1:0]  level_reg;
  logic              wr_en;
  logic              rd_en;

  assign full  = (level_reg == LVL_W'(DEPTH));
  assign empty = (level_reg == '0);
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;
  assign head  = mem[rd_ptr_reg];
  assign level = level_reg;

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   level_reg <= level_reg + LVL_W'(1);
        2'b01:   level_reg <= level_reg - LVL_W'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/shake_hand_recv_buf.sv
// Four-phase handshake receiver: synchronizes the sender request, captures
// words into a show-ahead FIFO and arms the handshake only when space exists.
module shake_hand_recv_buf
  import shake_hand_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ready,
  input  logic [DATA_W-1:0]          din,
  output logic                       ack,
  output logic [DATA_W-1:0]          dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       timeout
);

  localparam int TMR_W    = (TIMEOUT > 1) ? clog2(TIMEOUT) : 1;
  localparam int TMR_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   ready_s;
  hs_state_t              state_reg;
  logic                   ack_reg;
  logic                   timeout_reg;
  logic [TMR_W-1:0]       timer_reg;
  logic                   push;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [DATA_W-1:0]      fifo_head;

  always_ff @(posedge clk) begin
    if (!rst_n) sync_reg <= '0;
    else        sync_reg <= {sync_reg[SYNC_STAGES-2:0], ready};
  end
  assign ready_s = sync_reg[SYNC_STAGES-1];

  // din is stable while ack is high, so it is captured without synchronizing.
  assign push = (state_reg == WAIT_HI) && ready_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      ack_reg     <= 1'b0;
      timeout_reg <= 1'b0;
      timer_reg   <= '0;
    end else begin
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!fifo_full) begin
            state_reg <= WAIT_HI;
            ack_reg   <= 1'b1;
            timer_reg <= '0;
          end
        end
        WAIT_HI: begin
          if (ready_s) begin
            state_reg <= WAIT_LO;
            ack_reg   <= 1'b0;
          end else if (TIMEOUT > 0 && timer_reg == TMR_W'(TMR_LAST)) begin
            state_reg   <= WAIT_LO;
            ack_reg     <= 1'b0;
            timeout_reg <= 1'b1;
          end else begin
            timer_reg <= timer_reg + TMR_W'(1);
          end
        end
        WAIT_LO: begin
          // A request arriving after an abort is absorbed here without a push.
          if (!ready_s) state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          ack_reg   <= 1'b0;
        end
      endcase
    end
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (din),
    .pop       (pop),
    .head      (fifo_head),
    .level     (level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign dout_valid = ~fifo_empty;
  assign pop        = dout_valid & dout_ready;
  assign dout       = dout_valid ? fifo_head : '0;
  assign ack        = ack_reg;
  assign timeout    = timeout_reg;

endmodule

// File: tb/tb_shake_hand_recv_buf.sv
// Directed bench for shake_hand_recv_buf: handshake timing, backpressure,
// timeout abort, simultaneous push/pop, mid-handshake reset, 3-stage sync.
module tb_shake_hand_recv_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  // instance A: 8-bit, depth 4, 2 sync stages, timeout 10
  logic        ready_a, ack_a, dout_valid_a, dout_ready_a, timeout_a;
  logic [7:0]  din_a, dout_a;
  logic [2:0]  level_a;
  // instance B: 16-bit, depth 4, 3 sync stages, no timeout
  logic        ready_b, ack_b, dout_valid_b, dout_ready_b, timeout_b;
  logic [15:0] din_b, dout_b;
  logic [2:0]  level_b;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  shake_hand_recv_buf #(.DATA_W(8), .DEPTH(4), .SYNC_STAGES(2), .TIMEOUT(10)) u_a (
    .clk(clk), .rst_n(rst_n), .ready(ready_a), .din(din_a), .ack(ack_a),
    .dout(dout_a), .dout_valid(dout_valid_a), .dout_ready(dout_ready_a),
    .level(level_a), .timeout(timeout_a)
  );

  shake_hand_recv_buf #(.DATA_W(16), .DEPTH(4), .SYNC_STAGES(3), .TIMEOUT(0)) u_b (
    .clk(clk), .rst_n(rst_n), .ready(ready_b), .din(din_b), .ack(ack_b),
    .dout(dout_b), .dout_valid(dout_valid_b), .dout_ready(dout_ready_b),
    .level(level_b), .timeout(timeout_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack_rise(input string tag);
    logic prev;
    bit   seen;
    seen = 1'b0;
    prev = ack_a;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (ack_a && !prev) seen = 1'b1;
      prev = ack_a;
    end
    check({tag, "_arm"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_ack_fall(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (!ack_a) seen = 1'b1;
    end
    check({tag, "_ackfall"}, 32'(seen), 32'd1);
  endtask

  task automatic send(input string tag, input logic [7:0] data);
    wait_ack_rise(tag);
    din_a   = data;
    ready_a = 1'b1;
    wait_ack_fall(tag);
    ready_a = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    ready_a = 1'b0; din_a = '0; dout_ready_a = 1'b1;
    ready_b = 1'b0; din_b = '0; dout_ready_b = 1'b1;
    repeat (3) tick();
    check("rst_ack", 32'(ack_a), 32'd0);
    check("rst_valid", 32'(dout_valid_a), 32'd0);
    check("rst_level", 32'(level_a), 32'd0);
    check("rst_dout", 32'(dout_a), 32'd0);
    check("rst_timeout", 32'(timeout_a), 32'd0);

    // Single word: ready sampled at E2, capture at E4, pop at E5
    rst_n = 1'b1;
    tick();
    check("arm_after_rst", 32'(ack_a), 32'd1);
    din_a = 8'hA5; ready_a = 1'b1;
    tick(); tick();
    check("sw_ack_before", 32'(ack_a), 32'd1);
    check("sw_valid_before", 32'(dout_valid_a), 32'd0);
    tick();
    check("sw_ack_cap", 32'(ack_a), 32'd0);
    check("sw_valid_cap", 32'(dout_valid_a), 32'd1);
    check("sw_dout_cap", 32'(dout_a), 32'hA5);
    check("sw_level_cap", 32'(level_a), 32'd1);
    tick();
    check("sw_valid_pop", 32'(dout_valid_a), 32'd0);
    check("sw_dout_pop", 32'(dout_a), 32'd0);
    ready_a = 1'b0;
    tick(); tick(); tick();
    check("sw_rearm_early", 32'(ack_a), 32'd0);
    tick();
    check("sw_rearm", 32'(ack_a), 32'd1);

    // Backpressure: fill four words with no downstream accept
    dout_ready_a = 1'b0;
    send("bp1", 8'h01);
    send("bp2", 8'h02);
    send("bp3", 8'h03);
    send("bp4", 8'h04);
    repeat (8) tick();
    check("bp_level_full", 32'(level_a), 32'd4);
    check("bp_ack_full", 32'(ack_a), 32'd0);
    check("bp_head", 32'(dout_a), 32'h01);
    dout_ready_a = 1'b1;
    tick();
    dout_ready_a = 1'b0;
    check("bp_level_pop", 32'(level_a), 32'd3);
    check("bp_head_pop", 32'(dout_a), 32'h02);
    check("bp_ack_pop", 32'(ack_a), 32'd0);
    tick();
    check("bp_ack_release", 32'(ack_a), 32'd1);
    send("bp5", 8'h05);
    check("bp_level_refill", 32'(level_a), 32'd4);
    dout_ready_a = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      check("bp_drain_valid", 32'(dout_valid_a), 32'd1);
      check("bp_drain_data", 32'(dout_a), 32'(i));
      tick();
    end
    check("bp_drain_empty", 32'(level_a), 32'd0);

    // Timeout: ack rose at edge A; late ready after edge A+8 must be absorbed
    wait_ack_rise("to");
    for (int i = 1; i <= 9; i++) begin
      tick();
      check("to_armed_ack", 32'(ack_a), 32'd1);
      check("to_no_pulse", 32'(timeout_a), 32'd0);
      if (i == 8) begin
        din_a = 8'h77;
        ready_a = 1'b1;
      end
    end
    tick();
    check("to_pulse", 32'(timeout_a), 32'd1);
    check("to_ack_drop", 32'(ack_a), 32'd0);
    check("to_level", 32'(level_a), 32'd0);
    tick();
    check("to_pulse_end", 32'(timeout_a), 32'd0);
    repeat (3) tick();
    check("to_late_ack", 32'(ack_a), 32'd0);
    check("to_late_level", 32'(level_a), 32'd0);
    check("to_late_valid", 32'(dout_valid_a), 32'd0);
    ready_a = 1'b0;
    tick(); tick(); tick();
    check("to_rearm_early", 32'(ack_a), 32'd0);
    tick();
    check("to_rearm", 32'(ack_a), 32'd1);
    check("to_rearm_level", 32'(level_a), 32'd0);

    // Simultaneous push and pop with level 1
    dout_ready_a = 1'b0;
    send("sp10", 8'h10);
    check("sp_level1", 32'(level_a), 32'd1);
    check("sp_head10", 32'(dout_a), 32'h10);
    wait_ack_rise("sp11");
    din_a = 8'h11; ready_a = 1'b1;
    tick(); tick();
    dout_ready_a = 1'b1;
    tick();
    dout_ready_a = 1'b0;
    check("sp_cap_ack", 32'(ack_a), 32'd0);
    check("sp_cap_level", 32'(level_a), 32'd1);
    check("sp_cap_head", 32'(dout_a), 32'h11);
    ready_a = 1'b0;
    send("sp12", 8'h12);
    check("sp_level2", 32'(level_a), 32'd2);
    dout_ready_a = 1'b1;
    check("sp_out11", 32'(dout_a), 32'h11);
    tick();
    check("sp_out12", 32'(dout_a), 32'h12);
    tick();
    check("sp_empty", 32'(dout_valid_a), 32'd0);

    // Reset while armed (WAIT_HI) with two words buffered
    dout_ready_a = 1'b0;
    send("r21", 8'h21);
    send("r22", 8'h22);
    wait_ack_rise("rhi");
    check("rhi_level_pre", 32'(level_a), 32'd2);
    rst_n = 1'b0;
    tick();
    check("rhi_ack", 32'(ack_a), 32'd0);
    check("rhi_valid", 32'(dout_valid_a), 32'd0);
    check("rhi_level", 32'(level_a), 32'd0);
    check("rhi_dout", 32'(dout_a), 32'd0);
    rst_n = 1'b1;
    send("r31", 8'h31);
    check("rhi_after_level", 32'(level_a), 32'd1);
    check("rhi_after_head", 32'(dout_a), 32'h31);

    // Reset in WAIT_LO right after the second word is captured
    wait_ack_rise("rlo");
    din_a = 8'h32; ready_a = 1'b1;
    wait_ack_fall("rlo");
    check("rlo_level_pre", 32'(level_a), 32'd2);
    rst_n = 1'b0; ready_a = 1'b0;
    tick();
    check("rlo_ack", 32'(ack_a), 32'd0);
    check("rlo_valid", 32'(dout_valid_a), 32'd0);
    check("rlo_level", 32'(level_a), 32'd0);
    check("rlo_dout", 32'(dout_a), 32'd0);
    rst_n = 1'b1;
    send("r41", 8'h41);
    check("rlo_after_level", 32'(level_a), 32'd1);
    check("rlo_after_head", 32'(dout_a), 32'h41);

    // Three-stage synchronizer, 16-bit data: capture at N+3
    check("b_armed", 32'(ack_b), 32'd1);
    din_b = 16'hBEEF; ready_b = 1'b1;
    tick(); tick(); tick();
    check("b_ack_before", 32'(ack_b), 32'd1);
    check("b_valid_before", 32'(dout_valid_b), 32'd0);
    tick();
    check("b_ack_cap", 32'(ack_b), 32'd0);
    check("b_valid_cap", 32'(dout_valid_b), 32'd1);
    check("b_dout_cap", 32'(dout_b), 32'hBEEF);
    check("b_timeout", 32'(timeout_b), 32'd0);
    ready_b = 1'b0;
    tick();
    check("b_level_pop", 32'(level_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/shake_hand_recv_buf.md
# shake_hand_recv_buf

Parametrised four-phase handshake receiver with an input synchronizer, a receive FIFO and a handshake timeout. It sits at an asynchronous sender boundary:
- the sender presents `din` and raises `ready`;
- the block captures the word, buffers it, and presents it downstream as a valid/ready stream.

Flow control is built into the handshake: `ack` is raised (receiver armed) only while the FIFO has a free slot.

## Interface
Parameters:
- `DATA_W`, 8: data word width.
- `DEPTH`, 4: FIFO depth in words. Power of two, ≥ 2.
- `SYNC_STAGES`, 2: flops on `ready`. Minimum 2.
- `TIMEOUT`, 0: cycles armed without `ready` before abort. 0 disables the timeout.

Ports:
- `clk` input 1: single clock.
- `rst_n` input 1: reset, synchronous, active-low.
- `ready` input 1: sender request, asynchronous to `clk`.
- `din` input DATA_W: sender data. Sender holds it stable from before `ready` rises until it sees `ack` fall.
- `ack` output 1: registered. 1 = receiver armed for one word.
- `dout` output DATA_W: FIFO head. Forced to 0 while `dout_valid`=0.
- `dout_valid` output 1: FIFO non-empty.
- `dout_ready` input 1: downstream accept.
- `level` output $clog2(DEPTH+1): registered FIFO occupancy.
- `timeout` output 1: one-cycle pulse when an armed handshake aborts.

## Operation
- `ready` passes through a `SYNC_STAGES`-flop chain to produce `ready_s`. `din` is sampled directly on the capture edge.
- FSM states:
  - IDLE (`ack`=0): if `level` < DEPTH → WAIT_HI, setting `ack`<=1. Otherwise stay in IDLE.
  - WAIT_HI (`ack`=1):
    - if `ready_s`=1 → push `din` into the FIFO, `ack`<=0, go to WAIT_LO;
    - else if TIMEOUT>0 and the armed timer = TIMEOUT-1 → `ack`<=0, pulse `timeout`, go to WAIT_LO with no push;
    - else increment the timer.
    - The timer clears on entry to WAIT_HI.
  - WAIT_LO (`ack`=0): if `ready_s`=0 → IDLE.
  - Unused encodings → IDLE.
- A push can never hit a full FIFO, because arming requires a free slot and pops only free space. The implementation still guards the write enable with not-full.
- FIFO is show-ahead:
  - pop = `dout_valid` & `dout_ready`;
  - simultaneous push and pop leaves `level` unchanged;
  - read/write pointers wrap modulo DEPTH.
- Reset (`rst_n`=0 at an edge) clears:
  - sync flops, state → IDLE, timer;
  - pointers and `level` → 0;
  - `ack`=0, `timeout`=0, `dout_valid`=0, `dout`=0.
  - Buffered and in-flight words are discarded. Reset mid-handshake drops `ack` at that edge.

## Timing
- Capture latency: `ready` first sampled high at edge N → push, `ack` falls, and `level` increments at edge N+SYNC_STAGES. If the FIFO was empty, `dout_valid` rises after that same edge.
- Re-arm: `ready` first sampled low at edge M → IDLE at M+SYNC_STAGES → `ack` rises at M+SYNC_STAGES+1, given space.
- Backpressure release: a pop from a full FIFO at edge P → `level`=DEPTH-1 after P → `ack` rises at P+1 if in IDLE.
- Timeout: `ack` rises at edge A → abort and `timeout` pulse at edge A+TIMEOUT.
- Late `ready` after a timeout is absorbed by WAIT_LO; no word is pushed.
- Push→pop throughput is 1 word/cycle on the FIFO side. The handshake limits input to one word per ≥ 2·SYNC_STAGES+2 cycles.

## Structure
- Shared package `shake_hand_pkg`:
  - state encodings IDLE/WAIT_HI/WAIT_LO (2-bit);
  - a `clog2` helper function.
- Sub-module `sync_fifo` (params DATA_W, DEPTH): push, pop, head data, `level`, full/empty.
- Synchronizer chain and FSM stay in the top level.

## Test plan
- Single word, defaults, `dout_ready`=1: `din`=8'hA5, `ready` high → after edge N+2, `ack`=0 and `dout`=A5 with `dout_valid`=1 for one cycle; `ready` low → `ack` back high 3 cycles after it is sampled low.
- Backpressure, DEPTH=4, `dout_ready`=0:
  - send 4 words 01..04 → `level`=4 and `ack` stays 0 in IDLE;
  - pulse `dout_ready` one cycle → `dout`=01 popped, `ack` rises one edge later;
  - a 5th word 05 arrives last in order.
- Timeout, TIMEOUT=10: arm, keep `ready` low → `ack` falls and `timeout` pulses exactly 10 cycles after `ack` rose, `level` unchanged; a later `ready` high/low pair pushes nothing, then re-arms.
- Simultaneous push/pop: `level`=1 with `dout_ready`=1 on the capture edge → `level` stays 1, order preserved (sequence 10,11,12 emerges 10,11,12).
- Reset mid-handshake in WAIT_HI and in WAIT_LO with `level`=2 → `ack`, `dout_valid`, `level`, `dout` all 0 at that edge; the next handshake works from empty.
- SYNC_STAGES=3, DATA_W=16: `din`=16'hBEEF → capture at edge N+3, `dout`=BEEF.
